// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (core + debug/loader) round-robin arbiter in front of
// a single-ported data memory. Each access walks IDLE -> ISSUE -> RESP, so the
// memory sees at most one strobe per three cycles and never sees overlapping
// strobes.

module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  // core port
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_ack,
  output logic              c_stall,
  // debug / loader port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  // data memory
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state;

  // 1 = debug port won the most recent grant, 0 = core port
  logic last_grant;
  // identity of the port owning the access currently in flight
  logic win_d;

  logic              grant_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Pick the winner: a lone request wins, a tie goes to the port not granted last
  always_comb begin
    grant_d   = d_req & (~c_req | ~last_grant);
    sel_we    = grant_d ? d_we    : c_we;
    sel_addr  = grant_d ? d_addr  : c_addr;
    sel_wdata = grant_d ? d_wdata : c_wdata;
  end

  // The core must stall while its request is outstanding, but not in its ack cycle
  assign c_stall = c_req & ~c_ack;

  // Access sequencer; the memory strobes are registered so they are only
  // non-zero during ISSUE and drop immediately when reset asserts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      win_d      <= 1'b0;
      c_rdata    <= '0;
      d_rdata    <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          c_ack <= 1'b0;
          d_ack <= 1'b0;
          if (c_req | d_req) begin
            win_d      <= grant_d;
            last_grant <= grant_d;
            mem_re     <= ~sel_we;
            mem_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_re) begin
            if (win_d) d_rdata <= mem_rdata;
            else       c_rdata <= mem_rdata;
          end
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          c_ack     <= ~win_d;
          d_ack     <= win_d;
          state     <= RESP;
        end
        RESP: begin
          c_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= IDLE;
        end
        default: begin
          c_ack     <= 1'b0;
          d_ack     <= 1'b0;
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed, self-checking bench for dmem_arbiter. Inputs are
// driven and outputs sampled on the falling edge, half a cycle away from the
// rising edge where the arbiter samples.

module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              c_req, c_we, d_req, d_we;
  logic [ADDR_W-1:0] c_addr, d_addr;
  logic [DATA_W-1:0] c_wdata, d_wdata;
  logic [DATA_W-1:0] c_rdata, d_rdata;
  logic              c_ack, d_ack, c_stall;
  logic              mem_re, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_ack(c_ack), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs right after an asynchronous reset, then release
  task automatic test_reset();
    reset = 1'b1; c_req = 1'b1; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({c_ack, d_ack, mem_re, mem_we} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes got %b want 0000", {c_ack, d_ack, mem_re, mem_we});
    end
    tests_run++;
    if ({c_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs c_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h want all 0",
               c_rdata, d_rdata, mem_addr, mem_wdata);
    end
    tests_run++;
    if (c_stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_stall got %b want 1", c_stall);
    end
    c_req = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({c_ack, mem_re, c_stall} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL idle_quiet got %b want 000", {c_ack, mem_re, c_stall});
    end
  endtask

  // Core read of 0x10 returning 0xDEADBEEF
  task automatic test_core_read();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; c_wdata = 32'h0; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    tests_run++;
    if ({mem_re, mem_we, c_ack, c_stall} !== 4'b1001 || mem_addr !== 32'h10) begin
      tests_failed++;
      $display("[TB] FAIL cread_issue re/we/ack/stall=%b addr=%h want 1001 addr=00000010",
               {mem_re, mem_we, c_ack, c_stall}, mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if ({mem_re, mem_we, c_ack, d_ack, c_stall} !== 5'b00100) begin
      tests_failed++;
      $display("[TB] FAIL cread_resp re/we/cack/dack/stall=%b want 00100",
               {mem_re, mem_we, c_ack, d_ack, c_stall});
    end
    tests_run++;
    if (c_rdata !== 32'hDEADBEEF || d_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL cread_data c_rdata=%h d_rdata=%h want deadbeef 00000000", c_rdata, d_rdata);
    end
    c_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({c_ack, mem_re, mem_addr} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL cread_idle ack=%b re=%b addr=%h want zeros", c_ack, mem_re, mem_addr);
    end
  endtask

  // Debug write of 0x12345678 to 0x20; memory read data must not be captured
  task automatic test_debug_write();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h12345678; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    tests_run++;
    if ({mem_re, mem_we} !== 2'b01 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678) begin
      tests_failed++;
      $display("[TB] FAIL dwrite_issue re/we=%b addr=%h wdata=%h want 01 00000020 12345678",
               {mem_re, mem_we}, mem_addr, mem_wdata);
    end
    @(negedge clk);
    tests_run++;
    if ({mem_re, mem_we, c_ack, d_ack} !== 4'b0001 || mem_wdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL dwrite_resp re/we/cack/dack=%b wdata=%h want 0001 00000000",
               {mem_re, mem_we, c_ack, d_ack}, mem_wdata);
    end
    tests_run++;
    if (c_rdata !== 32'hDEADBEEF || d_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL dwrite_data c_rdata=%h d_rdata=%h want deadbeef 00000000", c_rdata, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    tests_run++;
    if (d_ack !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL dwrite_ack_width d_ack=%b want 0", d_ack);
    end
  endtask

  // Both ports held after reset: grants alternate C, D, C, D, one every 3 cycles
  task automatic test_round_robin();
    logic exp_c;
    logic [DATA_W-1:0] exp_c_rdata, exp_d_rdata;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    exp_c_rdata = '0; exp_d_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      exp_c = (k % 2 == 0);
      mem_rdata = 32'hA000_0000 + k;
      if (exp_c) exp_c_rdata = 32'hA000_0000 + k;
      else       exp_d_rdata = 32'hA000_0000 + k;
      @(negedge clk);
      tests_run++;
      if (mem_re !== 1'b1 || mem_addr !== (exp_c ? 32'h100 : 32'h200)) begin
        tests_failed++;
        $display("[TB] FAIL rr_issue%0d re=%b addr=%h want 1 %h", k, mem_re, mem_addr,
                 exp_c ? 32'h100 : 32'h200);
      end
      @(negedge clk);
      tests_run++;
      if ({c_ack, d_ack, c_stall} !== {exp_c, ~exp_c, ~exp_c}) begin
        tests_failed++;
        $display("[TB] FAIL rr_resp%0d cack/dack/stall=%b want %b", k, {c_ack, d_ack, c_stall},
                 {exp_c, ~exp_c, ~exp_c});
      end
      tests_run++;
      if (c_rdata !== exp_c_rdata || d_rdata !== exp_d_rdata) begin
        tests_failed++;
        $display("[TB] FAIL rr_data%0d c_rdata=%h d_rdata=%h want %h %h", k, c_rdata, d_rdata,
                 exp_c_rdata, exp_d_rdata);
      end
      @(negedge clk);
      tests_run++;
      if ({c_ack, d_ack, mem_re, c_stall} !== 4'b0001) begin
        tests_failed++;
        $display("[TB] FAIL rr_idle%0d cack/dack/re/stall=%b want 0001", k,
                 {c_ack, d_ack, mem_re, c_stall});
      end
    end
    c_req = 1'b0; d_req = 1'b0;
  endtask

  // Debug request arriving during a core ISSUE waits for the next IDLE edge
  task automatic test_back_to_back();
    c_req = 1'b1; c_we = 1'b0; c_addr = 32'h10; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
    tests_run++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h10) begin
      tests_failed++;
      $display("[TB] FAIL b2b_core_issue re=%b addr=%h want 1 00000010", mem_re, mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if ({c_ack, d_ack, mem_re, mem_we} !== 4'b1000 || c_rdata !== 32'h1111_2222) begin
      tests_failed++;
      $display("[TB] FAIL b2b_core_resp cack/dack/re/we=%b c_rdata=%h want 1000 11112222",
               {c_ack, d_ack, mem_re, mem_we}, c_rdata);
    end
    c_req = 1'b0;
    mem_rdata = 32'h3333_4444;
    @(negedge clk);
    tests_run++;
    if ({c_ack, d_ack, mem_re, mem_we} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL b2b_idle cack/dack/re/we=%b want 0000", {c_ack, d_ack, mem_re, mem_we});
    end
    @(negedge clk);
    tests_run++;
    if (mem_re !== 1'b1 || mem_addr !== 32'h44) begin
      tests_failed++;
      $display("[TB] FAIL b2b_dbg_issue re=%b addr=%h want 1 00000044", mem_re, mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if ({c_ack, d_ack} !== 2'b01 || d_rdata !== 32'h3333_4444 || c_rdata !== 32'h1111_2222) begin
      tests_failed++;
      $display("[TB] FAIL b2b_dbg_resp cack/dack=%b d_rdata=%h c_rdata=%h want 01 33334444 11112222",
               {c_ack, d_ack}, d_rdata, c_rdata);
    end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  // Reset pulsed during the ISSUE cycle of a core write
  task automatic test_reset_mid_write();
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h30; c_wdata = 32'hCAFEF00D;
    @(negedge clk);
    tests_run++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D) begin
      tests_failed++;
      $display("[TB] FAIL rst_write_issue we=%b wdata=%h want 1 cafef00d", mem_we, mem_wdata);
    end
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({mem_re, mem_we} !== 2'b00 || mem_addr !== 32'h0 || c_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL rst_abort re/we=%b addr=%h c_rdata=%h d_rdata=%h want 00 and zeros",
               {mem_re, mem_we}, mem_addr, c_rdata, d_rdata);
    end
    c_we = 1'b0; c_addr = 32'h50; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    tests_run++;
    if ({c_ack, d_ack, mem_we} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL rst_no_ack cack/dack/we=%b want 000", {c_ack, d_ack, mem_we});
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mem_re, mem_we} !== 2'b10 || mem_addr !== 32'h50) begin
      tests_failed++;
      $display("[TB] FAIL rst_next_issue re/we=%b addr=%h want 10 00000050", {mem_re, mem_we}, mem_addr);
    end
    @(negedge clk);
    tests_run++;
    if (c_ack !== 1'b1 || c_rdata !== 32'h5555_AAAA) begin
      tests_failed++;
      $display("[TB] FAIL rst_next_resp c_ack=%b c_rdata=%h want 1 5555aaaa", c_ack, c_rdata);
    end
    c_req = 1'b0;
    @(negedge clk);
  endtask

  // Run every scenario in order and report
  initial begin
    test_reset();
    test_core_read();
    test_debug_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 32, address width; DATA_W, default 32, data width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 c_req  input  1  core load/store request, held until c_ack.
REQ-005 c_we  input  1  core access type; 1 = write, 0 = read.
REQ-006 c_addr  input  ADDR_W  core byte address.
REQ-007 c_wdata  input  DATA_W  core write data.
REQ-008 c_rdata  output  DATA_W  core read data, registered.
REQ-009 c_ack  output  1  one-cycle completion pulse to the core.
REQ-010 c_stall  output  1  hold-PC/pipeline indication to the core.
REQ-011 d_req, d_we, d_addr, d_wdata  input  1/1/ADDR_W/DATA_W  debug/loader port, same semantics as the core port.
REQ-012 d_rdata  output  DATA_W; d_ack  output  1  debug-port read data and completion pulse.
REQ-013 mem_re, mem_we  output  1  data-memory read and write strobes.
REQ-014 mem_addr  output  ADDR_W; mem_wdata  output  DATA_W  data-memory address and write data.
REQ-015 mem_rdata  input  DATA_W  data-memory read data, valid in the cycle mem_re is high.

Function
REQ-016 FSM states: IDLE, ISSUE, RESP; encoding is free; no other reachable state.
REQ-017 IDLE: if any req is high at the clock edge, latch the winner id, we, addr, wdata and go to ISSUE; else stay in IDLE.
REQ-018 Single request: grant that port. Both requests: grant the port not in last_grant (round-robin).
REQ-019 last_grant updates to the winner on every grant.
REQ-020 ISSUE lasts exactly 1 cycle: drive the latched mem_addr and mem_wdata; mem_we = latched we; mem_re = ~latched we.
REQ-021 In ISSUE, on a read, capture mem_rdata into the winner's rdata register; the other port's rdata is unchanged.
REQ-022 A write never modifies either rdata register.
REQ-023 ISSUE goes to RESP unconditionally.
REQ-024 RESP: assert exactly one ack, for the latched winner, for 1 cycle; next state IDLE.
REQ-025 mem_re, mem_we, mem_addr and mem_wdata SHALL be 0 in every state except ISSUE.
REQ-026 Latency: request sampled at edge N gives ack high in cycle N+2; peak throughput is 1 access per 3 cycles.
REQ-027 A requester SHALL hold req, we, addr and wdata stable until ack; the arbiter samples them only at the IDLE edge.
REQ-028 A req still high in the IDLE cycle after ack is treated as a new request.
REQ-029 c_stall = c_req & ~c_ack, combinational; it is low in the ack cycle so the core advances.
REQ-030 rdata registers hold their value until the next read completion for that port.
REQ-031 Address and data pass through unmodified: no alignment check and no byte-lane logic in this block.
REQ-032 d_req arriving while a core access is in ISSUE or RESP waits for IDLE; an in-flight access is never pre-empted.

Reset
REQ-033 On reset (asynchronous assert): state = IDLE; last_grant = D, so the core wins the first tie; c_rdata = d_rdata = 0; all acks and mem strobes = 0.
REQ-034 Reset asserted mid-access aborts the access: no ack is issued, and a write in ISSUE is suppressed from the reset edge onward.
REQ-035 After reset release, operation begins from IDLE at the first rising edge; pending reqs are re-arbitrated under REQ-018.

Verification
REQ-036 Core read: c_req = 1, c_we = 0, c_addr = 0x10, memory returns 0xDEADBEEF -> mem_re high 1 cycle with mem_addr = 0x10; c_ack in cycle N+2; c_rdata = 0xDEADBEEF; d_rdata unchanged.
REQ-037 Debug write: d_we = 1, d_addr = 0x20, d_wdata = 0x12345678 -> mem_we high exactly 1 cycle with those values; d_ack 1 cycle; c_rdata and d_rdata unchanged.
REQ-038 Simultaneous requests held for 4 accesses after reset -> grant order C, D, C, D; acks 3 cycles apart; c_stall high except in c_ack cycles.
REQ-039 d_req raised during a core ISSUE -> core access completes, then the debug access is granted on the next IDLE edge; no strobe overlap.
REQ-040 Reset pulsed during ISSUE of a write -> no ack; strobes 0 from the reset edge; state IDLE; rdata = 0; the next request completes normally.
